// File: rtl/debounce_scheduler.sv
// Multi-channel early-response debouncer: each output follows its input's first edge,
// then ignores the input for a tick-paced lockout; edge events are round-robin arbitrated.
//
// Channel FSM states:
//   state | meaning
//   IDLE  | db tracks s; a mismatch updates db, posts an event and starts the lockout
//   LOCK  | input ignored; lock counter decrements on each prescaler tick
module debounce_scheduler #(
    parameter int N_CH    = 4,
    parameter int TICK_M  = 1_000_000,
    parameter int N_TICKS = 3,
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int PW = $clog2(TICK_M)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db,
    output logic            ev_valid,
    output logic [CW-1:0]   ev_ch,
    output logic            ev_rise,
    input  logic            ev_ready,
    output logic [N_CH-1:0] ovf,
    input  logic            ovf_clr
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } ch_state_t;

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] s;
    logic [PW-1:0]   pcnt;
    logic            tick;

    ch_state_t       state    [N_CH];
    ch_state_t       state_nx [N_CH];
    logic [3:0]      cnt      [N_CH];
    logic [3:0]      cnt_nx   [N_CH];
    logic [N_CH-1:0] db_nx;
    logic [N_CH-1:0] post;

    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] pol;
    logic [N_CH-1:0] ovf_set;
    logic [CW-1:0]   rr_ptr;
    logic [CW-1:0]   grant;
    logic [CW-1:0]   grant_nxt;
    logic            found;
    logic            load;
    logic            take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= sw;
            s     <= sync1;
        end
    end

    assign tick = (pcnt == PW'(TICK_M - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_nx[i] = state[i];
            cnt_nx[i]   = cnt[i];
            db_nx[i]    = db[i];
            post[i]     = 1'b0;
            case (state[i])
                IDLE: begin
                    if (s[i] != db[i]) begin
                        db_nx[i]    = s[i];
                        cnt_nx[i]   = 4'(N_TICKS);
                        state_nx[i] = LOCK;
                        post[i]     = 1'b1;
                    end
                end
                LOCK: begin
                    if (tick) begin
                        cnt_nx[i] = cnt[i] - 4'd1;
                        if (cnt[i] == 4'd1) begin
                            state_nx[i] = IDLE;
                        end
                    end
                end
                default: state_nx[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            db <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= state_nx[i];
                cnt[i]   <= cnt_nx[i];
            end
            db <= db_nx;
        end
    end

    // Scan offsets high-to-low so the closest pending channel at or after rr_ptr wins.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (pending[idx]) begin
                found = 1'b1;
                grant = CW'(idx);
            end
        end
    end

    assign load      = !ev_valid || ev_ready;
    assign take      = load && found;
    assign grant_nxt = (grant == CW'(N_CH - 1)) ? '0 : grant + 1'b1;

    // A post coinciding with the load of its own old event is not an overrun.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ovf_set[i] = post[i] && pending[i] && !(take && (grant == CW'(i)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            pol     <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (post[i]) begin
                    pending[i] <= 1'b1;
                    pol[i]     <= s[i];
                end else if (take && (grant == CW'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & ~{N_CH{ovf_clr}}) | ovf_set;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_valid <= 1'b0;
            ev_ch    <= '0;
            ev_rise  <= 1'b0;
            rr_ptr   <= '0;
        end else if (load) begin
            if (found) begin
                ev_valid <= 1'b1;
                ev_ch    <= grant;
                ev_rise  <= pol[grant];
                rr_ptr   <= grant_nxt;
            end else begin
                ev_valid <= 1'b0;
            end
        end
    end

endmodule
